// File: rtl/uc_rr_arbiter.sv
// Unit-clause arbiter: merges memory and engine literals into a broadcast FIFO, dropping duplicates and flagging conflicts.
// Latency: grant/pop are combinational; an accepted literal is on out_valid/gst_valid one cycle later.
// Backpressure: no grant while conflict is set or the FIFO is full (unless the head leaves the same cycle); out_ready drains the head.
module uc_rr_arbiter #(
  parameter int NUM_ENGINE = 4,
  parameter int LIT_W      = 16,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        mem_valid,
  input  logic [LIT_W-1:0]            mem_lit,
  output logic                        mem_ready,
  input  logic [NUM_ENGINE-1:0]       eng_valid,
  input  logic [NUM_ENGINE*LIT_W-1:0] eng_lit,
  output logic [NUM_ENGINE-1:0]       eng_pop,
  output logic                        out_valid,
  output logic [LIT_W-1:0]            out_lit,
  input  logic                        out_ready,
  output logic                        gst_valid,
  output logic [LIT_W-1:0]            gst_lit,
  output logic                        conflict,
  output logic [LIT_W-1:0]            conflict_lit,
  input  logic                        conflict_clr,
  output logic [$clog2(DEPTH):0]      count,
  output logic [15:0]                 dup_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

  // Advance an engine pointer, wrapping at NUM_ENGINE (which need not be a power of 2).
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    if (int'(p) >= NUM_ENGINE - 1) return '0;
    return p + 1'b1;
  endfunction

  logic [LIT_W-1:0] eng_lit_a [NUM_ENGINE];
  logic [LIT_W-1:0] fifo_q    [DEPTH];
  logic [DEPTH-1:0] occ_q, occ_d;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    eng_idx;
  logic [PW-1:0]    scan_idx;
  logic [LIT_W-1:0] cand_lit;
  logic [LIT_W-1:0] comp_lit;
  logic             pop, space, allow;
  logic             mem_gnt, eng_gnt, grant;
  logic             dup_hit, cmp_hit;
  logic             push, new_conf, new_dup;
  int               idx;

  for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_unpack
    assign eng_lit_a[g] = eng_lit[g*LIT_W +: LIT_W];
  end

  assign out_valid = (count_q != '0);
  assign out_lit   = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign pop       = out_valid && out_ready;
  // A full FIFO still has room when its head leaves in the same cycle.
  assign space     = (count_q < CW'(DEPTH)) || pop;
  // conflict_clr suppresses grants so a flush never races with a push or a new conflict.
  assign allow     = rst && !conflict && !conflict_clr && space;

  // Source selection: memory first, then round-robin search or the single masked engine.
  always_comb begin
    mem_gnt  = 1'b0;
    eng_gnt  = 1'b0;
    eng_idx  = ptr_q;
    ptr_d    = ptr_q;
    idx      = 0;
    scan_idx = '0;
    if (allow) begin
      if (mem_valid) begin
        mem_gnt = 1'b1;
      end else if (mode) begin
        for (int k = 0; k < NUM_ENGINE; k++) begin
          idx = int'(ptr_q) + k;
          if (idx >= NUM_ENGINE) idx = idx - NUM_ENGINE;
          scan_idx = PW'(idx);
          if (!eng_gnt && eng_valid[scan_idx]) begin
            eng_gnt = 1'b1;
            eng_idx = scan_idx;
          end
        end
        if (eng_gnt) ptr_d = inc_ptr(eng_idx);
      end else if (eng_valid[ptr_q]) begin
        eng_gnt = 1'b1;
        eng_idx = ptr_q;
      end else begin
        ptr_d = inc_ptr(ptr_q);
      end
    end
  end

  // Handshake outputs follow the grant combinationally.
  always_comb begin
    eng_pop = '0;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      eng_pop[i] = eng_gnt && (eng_idx == PW'(i));
    end
  end

  assign mem_ready = mem_gnt;
  assign grant     = mem_gnt || eng_gnt;
  assign cand_lit  = mem_gnt ? mem_lit : eng_lit_a[eng_idx];
  assign comp_lit  = {cand_lit[LIT_W-1:1], ~cand_lit[0]};

  // Compare the candidate against every occupied FIFO slot for exact and complementary matches.
  always_comb begin
    dup_hit = 1'b0;
    cmp_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i]) begin
        if (fifo_q[i] == cand_lit) dup_hit = 1'b1;
        if (fifo_q[i] == comp_lit) cmp_hit = 1'b1;
      end
    end
  end

  // Complement beats duplicate when both are present.
  assign push     = grant && !dup_hit && !cmp_hit;
  assign new_conf = grant && cmp_hit;
  assign new_dup  = grant && dup_hit && !cmp_hit;

  // Next occupancy map: free the slot being read, then mark the slot being written (same slot when full).
  always_comb begin
    occ_d = occ_q;
    if (pop)  occ_d[rd_ptr_q] = 1'b0;
    if (push) occ_d[wr_ptr_q] = 1'b1;
  end

  // FIFO pointers, occupancy and count; conflict_clr flushes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
    end else if (conflict_clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Literal storage; stale slots are masked by the occupancy map so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= cand_lit;
  end

  // Status: accept pulse, duplicate counter, engine pointer and sticky conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gst_valid    <= 1'b0;
      gst_lit      <= '0;
      dup_drops    <= '0;
      ptr_q        <= '0;
      conflict     <= 1'b0;
      conflict_lit <= '0;
    end else begin
      gst_valid <= push;
      if (push) gst_lit <= cand_lit;
      if (new_dup && (dup_drops != 16'hFFFF)) dup_drops <= dup_drops + 1'b1;
      ptr_q <= ptr_d;
      if (conflict_clr) begin
        conflict     <= 1'b0;
        conflict_lit <= '0;
      end else if (new_conf) begin
        conflict     <= 1'b1;
        conflict_lit <= cand_lit;
      end
    end
  end

endmodule

// File: tb/tb_uc_rr_arbiter.sv
// Directed bench for uc_rr_arbiter with default parameters (4 engines, 16-bit literals, 8-deep FIFO).
// Inputs change 1 time unit after the rising edge; outputs are sampled between edges.
// Each scenario task compares observed values against hand-computed expectations.
module tb_uc_rr_arbiter;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        mem_valid;
  logic [15:0] mem_lit;
  logic        mem_ready;
  logic [3:0]  eng_valid;
  logic [63:0] eng_lit;
  logic [3:0]  eng_pop;
  logic        out_valid;
  logic [15:0] out_lit;
  logic        out_ready;
  logic        gst_valid;
  logic [15:0] gst_lit;
  logic        conflict;
  logic [15:0] conflict_lit;
  logic        conflict_clr;
  logic [3:0]  count;
  logic [15:0] dup_drops;

  int n_chk;
  int n_fail;

  uc_rr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .mem_valid    (mem_valid),
    .mem_lit      (mem_lit),
    .mem_ready    (mem_ready),
    .eng_valid    (eng_valid),
    .eng_lit      (eng_lit),
    .eng_pop      (eng_pop),
    .out_valid    (out_valid),
    .out_lit      (out_lit),
    .out_ready    (out_ready),
    .gst_valid    (gst_valid),
    .gst_lit      (gst_lit),
    .conflict     (conflict),
    .conflict_lit (conflict_lit),
    .conflict_clr (conflict_clr),
    .count        (count),
    .dup_drops    (dup_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    mem_valid    = 1'b0;
    eng_valid    = 4'b0000;
    conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 1'b1; mem_valid = 1'b0; mem_lit = 16'h0;
    eng_valid = 4'b1011; eng_lit = 64'h0; out_ready = 1'b1; conflict_clr = 1'b0;
    eng_lit[0*16 +: 16] = 16'h0010;
    eng_lit[1*16 +: 16] = 16'h0020;
    eng_lit[3*16 +: 16] = 16'h0040;
    #3;
    n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_lit !== 16'h0) begin n_fail++; $display("FAIL reset_out_lit: got %h want 0", out_lit); end
    n_chk++; if (gst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gst_valid: got %b want 0", gst_valid); end
    n_chk++; if (gst_lit !== 16'h0) begin n_fail++; $display("FAIL reset_gst_lit: got %h want 0", gst_lit); end
    n_chk++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", conflict); end
    n_chk++; if (conflict_lit !== 16'h0) begin n_fail++; $display("FAIL reset_conflict_lit: got %h want 0", conflict_lit); end
    n_chk++; if (dup_drops !== 16'h0) begin n_fail++; $display("FAIL reset_dup_drops: got %0d want 0", dup_drops); end
    n_chk++; if (eng_pop !== 4'b0000) begin n_fail++; $display("FAIL reset_eng_pop: got %b want 0000", eng_pop); end
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
  endtask

  // Engines 0,1,3 valid: grants 0,1,3,0 with pointer 1,2,0,1.
  task automatic test_rr();
    logic [3:0]  exp_pop [4];
    logic [1:0]  exp_ptr [4];
    logic [15:0] exp_gst [4];
    exp_pop = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_ptr = '{2'd1, 2'd2, 2'd0, 2'd1};
    exp_gst = '{16'h0010, 16'h0020, 16'h0040, 16'h0010};
    step();
    rst = 1'b1;
    #1;
    n_chk++; if (eng_pop !== exp_pop[0]) begin n_fail++; $display("FAIL rr_pop0: got %b want %b", eng_pop, exp_pop[0]); end
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rr_mem_ready: got %b want 0", mem_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++; if (dut.ptr_q !== exp_ptr[k]) begin n_fail++; $display("FAIL rr_ptr%0d: got %0d want %0d", k, dut.ptr_q, exp_ptr[k]); end
      n_chk++; if (gst_valid !== 1'b1 || gst_lit !== exp_gst[k]) begin n_fail++; $display("FAIL rr_gst%0d: got %b/%h want 1/%h", k, gst_valid, gst_lit, exp_gst[k]); end
      if (k < 3) begin
        n_chk++; if (eng_pop !== exp_pop[k+1]) begin n_fail++; $display("FAIL rr_pop%0d: got %b want %b", k + 1, eng_pop, exp_pop[k+1]); end
      end
    end
    eng_valid = 4'b0000;
  endtask

  task automatic test_mem_push();
    flush();
    out_ready = 1'b0;
    mem_valid = 1'b1; mem_lit = 16'h0006;
    #1;
    n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL mem_ready: got %b want 1", mem_ready); end
    step();
    mem_valid = 1'b0;
    n_chk++; if (gst_valid !== 1'b1 || gst_lit !== 16'h0006) begin n_fail++; $display("FAIL mem_gst: got %b/%h want 1/0006", gst_valid, gst_lit); end
    n_chk++; if (out_valid !== 1'b1 || out_lit !== 16'h0006) begin n_fail++; $display("FAIL mem_out: got %b/%h want 1/0006", out_valid, out_lit); end
    n_chk++; if (count !== 4'd1) begin n_fail++; $display("FAIL mem_count: got %0d want 1", count); end
    step();
    n_chk++; if (gst_valid !== 1'b0) begin n_fail++; $display("FAIL mem_gst_pulse: got %b want 0", gst_valid); end
  endtask

  task automatic test_dup();
    flush();
    mem_valid = 1'b1; mem_lit = 16'h0008;
    step();
    mem_valid = 1'b0;
    eng_lit[0*16 +: 16] = 16'h0008;
    eng_valid = 4'b0001;
    #1;
    n_chk++; if (eng_pop !== 4'b0001) begin n_fail++; $display("FAIL dup_pop: got %b want 0001", eng_pop); end
    step();
    eng_valid = 4'b0000;
    n_chk++; if (count !== 4'd1) begin n_fail++; $display("FAIL dup_count: got %0d want 1", count); end
    n_chk++; if (dup_drops !== 16'd1) begin n_fail++; $display("FAIL dup_drops: got %0d want 1", dup_drops); end
    n_chk++; if (gst_valid !== 1'b0) begin n_fail++; $display("FAIL dup_gst: got %b want 0", gst_valid); end
  endtask

  task automatic test_conflict();
    flush();
    mem_valid = 1'b1; mem_lit = 16'h0008;
    step();
    mem_lit = 16'h0009;
    #1;
    n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL conf_ready: got %b want 1", mem_ready); end
    step();
    n_chk++; if (conflict !== 1'b1 || conflict_lit !== 16'h0009) begin n_fail++; $display("FAIL conf_flag: got %b/%h want 1/0009", conflict, conflict_lit); end
    n_chk++; if (count !== 4'd1 || gst_valid !== 1'b0) begin n_fail++; $display("FAIL conf_nopush: got %0d/%b want 1/0", count, gst_valid); end
    mem_lit = 16'h000A;
    #1;
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL conf_block: got %b want 0", mem_ready); end
    step();
    n_chk++; if (count !== 4'd1 || conflict !== 1'b1) begin n_fail++; $display("FAIL conf_hold: got %0d/%b want 1/1", count, conflict); end
    conflict_clr = 1'b1;
    #1;
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL conf_clr_block: got %b want 0", mem_ready); end
    step();
    conflict_clr = 1'b0; mem_valid = 1'b0;
    n_chk++; if (conflict !== 1'b0 || conflict_lit !== 16'h0) begin n_fail++; $display("FAIL conf_clear: got %b/%h want 0/0000", conflict, conflict_lit); end
    n_chk++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL conf_flush: got %0d/%b want 0/0", count, out_valid); end
    n_chk++; if (dup_drops !== 16'd1) begin n_fail++; $display("FAIL conf_dup_keep: got %0d want 1", dup_drops); end
    // Clear arriving together with a would-be conflict wins.
    mem_valid = 1'b1; mem_lit = 16'h0020;
    step();
    mem_lit = 16'h0021; conflict_clr = 1'b1;
    #1;
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL clrwin_ready: got %b want 0", mem_ready); end
    step();
    conflict_clr = 1'b0; mem_valid = 1'b0;
    n_chk++; if (conflict !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL clrwin_state: got %b/%0d want 0/0", conflict, count); end
  endtask

  task automatic test_full();
    flush();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_valid = 1'b1; mem_lit = 16'h0100 + 16'(2 * i);
      #1;
      n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b want 1", i, mem_ready); end
      step();
    end
    n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", count); end
    mem_lit = 16'h0200;
    #1;
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL full_block: got %b want 0", mem_ready); end
    step();
    n_chk++; if (count !== 4'd8 || gst_valid !== 1'b0) begin n_fail++; $display("FAIL full_hold: got %0d/%b want 8/0", count, gst_valid); end
    out_ready = 1'b1;
    #1;
    n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %b want 1", mem_ready); end
    step();
    out_ready = 1'b0; mem_valid = 1'b0;
    n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_pushpop_count: got %0d want 8", count); end
    n_chk++; if (out_lit !== 16'h0102) begin n_fail++; $display("FAIL full_head: got %h want 0102", out_lit); end
    n_chk++; if (gst_lit !== 16'h0200) begin n_fail++; $display("FAIL full_gst: got %h want 0200", gst_lit); end
  endtask

  // Asynchronous reset empties a full FIFO, then mask mode steps the pointer to engine 2.
  task automatic test_mask();
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (count !== 4'd0 || out_valid !== 1'b0 || out_lit !== 16'h0) begin n_fail++; $display("FAIL arst_fifo: got %0d/%b/%h want 0/0/0000", count, out_valid, out_lit); end
    n_chk++; if (dup_drops !== 16'd0) begin n_fail++; $display("FAIL arst_dup: got %0d want 0", dup_drops); end
    mode = 1'b0; eng_valid = 4'b0100; eng_lit[2*16 +: 16] = 16'h0030;
    step();
    rst = 1'b1;
    #1;
    n_chk++; if (eng_pop !== 4'b0000) begin n_fail++; $display("FAIL mask_pop0: got %b want 0000", eng_pop); end
    step();
    n_chk++; if (dut.ptr_q !== 2'd1 || eng_pop !== 4'b0000) begin n_fail++; $display("FAIL mask_step1: got %0d/%b want 1/0000", dut.ptr_q, eng_pop); end
    step();
    n_chk++; if (dut.ptr_q !== 2'd2 || eng_pop !== 4'b0100) begin n_fail++; $display("FAIL mask_step2: got %0d/%b want 2/0100", dut.ptr_q, eng_pop); end
    step();
    n_chk++; if (gst_valid !== 1'b1 || gst_lit !== 16'h0030) begin n_fail++; $display("FAIL mask_gst0: got %b/%h want 1/0030", gst_valid, gst_lit); end
    n_chk++; if (dut.ptr_q !== 2'd2 || eng_pop !== 4'b0100) begin n_fail++; $display("FAIL mask_hold: got %0d/%b want 2/0100", dut.ptr_q, eng_pop); end
    eng_lit[2*16 +: 16] = 16'h0032;
    step();
    n_chk++; if (gst_lit !== 16'h0032 || count !== 4'd2) begin n_fail++; $display("FAIL mask_gst1: got %h/%0d want 0032/2", gst_lit, count); end
    eng_valid = 4'b0000;
    #1;
    n_chk++; if (eng_pop !== 4'b0000) begin n_fail++; $display("FAIL mask_idle: got %b want 0000", eng_pop); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_rr();
    test_mem_push();
    test_dup();
    test_conflict();
    test_full();
    test_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
